mul_div_unit: RTL
=================

# mul_div_unit

Execute-stage multiply/divide unit for the 5-stage MIPS pipeline. It owns the HI/LO registers and executes MULT, MULTU, DIV and DIVU as multi-cycle operations. It accepts MTHI/MTLO writes and serves MFHI/MFLO reads. It is driven by the EXE-stage control signals: start/op derived from the ALU op encoding, `MUL_DIV_Sel`, and `MUL_DIV_Wr`. It raises a stall request to the hazard unit while an operation is in flight.

## Interface
- `MUL_LAT`, default 5: busy cycles for MULT/MULTU.
- `DIV_LAT`, default 10: busy cycles for DIV/DIVU.
- `clk` input 1: single clock; all state changes on its rising edge.
- `rst` input 1: reset, asynchronous and active-low; clears all state.
- `start` input 1: a MULT/MULTU/DIV/DIVU instruction is in EXE this cycle.
- `op` input 2: operation when `start` is high: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- `A` input 32: rs operand, after forwarding.
- `B` input 32: rt operand, after forwarding.
- `MUL_DIV_Sel` input 1: 1 selects HI, 0 selects LO, for both the read data and `MUL_DIV_Wr`.
- `MUL_DIV_Wr` input 1: MTHI/MTLO write enable; data is `A`.
- `flush` input 1: exception/ERET cancel of the EXE instruction and any in-flight operation.
- `busy` output 1: an operation is in flight (registered).
- `stall` output 1: `start | busy` (combinational); to the hazard unit.
- `HI_LO` output 32: `MUL_DIV_Sel ? HI : LO` (combinational).
- `HI` output 32: current HI register.
- `LO` output 32: current LO register.

## Operation
- States: IDLE, MUL, DIV. A down-counter `cnt` holds the remaining busy cycles.
- IDLE, `start=1`, `flush=0`:
  - Latch the operands and compute the result into shadow registers `res_hi`/`res_lo`.
  - Load `cnt` = `MUL_LAT` or `DIV_LAT`.
  - Go to MUL (op[1]=0) or DIV (op[1]=1).
- MUL/DIV: decrement `cnt` each cycle. On the cycle where `cnt`=1, commit HI←`res_hi`, LO←`res_lo` and return to IDLE.
- Arithmetic:
  - MULT: 64-bit signed product of A×B; HI = bits [63:32], LO = bits [31:0].
  - MULTU: same, unsigned.
  - DIV: signed. LO = quotient, truncated toward zero. HI = remainder, with the sign of the dividend.
  - DIVU: unsigned quotient and remainder.
  - Divide by zero: LO = 0xFFFFFFFF, HI = A, for both DIV and DIVU.
  - DIV of 0x80000000 by 0xFFFFFFFF: LO = 0x80000000, HI = 0.
- MTHI/MTLO: in IDLE with `start=0`, `MUL_DIV_Wr=1` writes `A` into HI (Sel=1) or LO (Sel=0) at the clock edge.
- Reads: `HI_LO`, `HI` and `LO` always show the committed registers. In-flight results are never visible.

## Timing
- Reset (async, `rst`=0): HI=0, LO=0, state IDLE, cnt=0, `busy`=0. Consequently `stall`=`start` and `HI_LO`=0.
- Operation latency, with `start` sampled at edge E0:
  - `busy` is 1 from E0 through E(N-1), i.e. exactly N cycles, where N = `MUL_LAT` or `DIV_LAT`.
  - HI/LO update at edge EN, the same edge at which `busy` falls.
  - An MFHI/MFLO in EXE after `busy` falls reads the new value.
- `stall` is high in the `start` cycle itself, so the following instruction holds in ID.
- Boundary conditions:
  - `start` while `busy`=1: ignored. The hazard unit must prevent this; the bench checks for no state change.
  - `MUL_DIV_Wr` while `busy`=1 or `start`=1: ignored.
  - `flush`=1 while busy: abort. State goes to IDLE at the next edge, HI/LO keep their pre-operation values, and `busy` is 0 the next cycle.
  - `flush`=1 together with `start` or `MUL_DIV_Wr`: both are ignored.
  - `flush`=1 in the commit cycle (`cnt`=1): flush wins and there is no commit.
  - `rst` asserted mid-operation: immediate return to the reset values. No partial commit.

## Test plan
- Reset then MTHI/MTLO: write A=0x12345678 with Sel=1, then A=0x9ABCDEF0 with Sel=0 → HI=0x12345678, LO=0x9ABCDEF0. `HI_LO` follows `MUL_DIV_Sel`.
- MULT A=0xFFFFFFFE, B=3 → `busy` high for exactly 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFA. MULTU with the same operands → HI=0x00000002, LO=0xFFFFFFFA.
- DIV A=0xFFFFFFF9 (-7), B=2 → after 10 busy cycles LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU A=7, B=2 → LO=3, HI=1.
- Divide by zero: DIVU A=0x55, B=0 → LO=0xFFFFFFFF, HI=0x55. Overflow: DIV 0x80000000 / 0xFFFFFFFF → LO=0x80000000, HI=0.
- Flush at busy cycle 3 of a DIV → HI/LO unchanged from before the operation, `busy`=0 the next cycle. A second `start` while busy has no effect, and the first result is committed on time.
- Assert `rst` during MULT cycle 2 → all outputs 0 immediately. After release, `start` is accepted normally.

Source files
------------

// File: rtl/mul_div_unit.sv
// Purpose: EXE-stage MIPS multiply/divide unit owning HI/LO (MULT/MULTU/DIV/DIVU, MTHI/MTLO, MFHI/MFLO).
// Latency: HI/LO commit MUL_LAT or DIV_LAT cycles after start; reads of HI/LO are combinational.
// Backpressure: stall = start | busy holds the pipeline; start/writes during busy or flush are dropped.
module mul_div_unit #(
  parameter int MUL_LAT = 5,
  parameter int DIV_LAT = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        MUL_DIV_Sel,
  input  logic        MUL_DIV_Wr,
  input  logic        flush,
  output logic        busy,
  output logic        stall,
  output logic [31:0] HI_LO,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  localparam int CNT_W   = $clog2(MAX_LAT + 1);
  localparam logic [CNT_W-1:0] MUL_CNT = CNT_W'(MUL_LAT);
  localparam logic [CNT_W-1:0] DIV_CNT = CNT_W'(DIV_LAT);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      res_hi_q, res_hi_d;
  logic [31:0]      res_lo_q, res_lo_d;
  logic [31:0]      hi_q, hi_d;
  logic [31:0]      lo_q, lo_d;

  // Control strobes decoded from the FSM state.
  logic accept;
  logic commit;
  logic mt_wr;

  // Arithmetic intermediates.
  logic [63:0] a_sx, b_sx, a_zx, b_zx;
  logic [63:0] prod_s, prod_u;
  logic [31:0] a_mag, b_mag, den_s, q_s_mag, r_s_mag, q_s, r_s;
  logic [31:0] den_u, q_u, r_u;
  logic [31:0] calc_hi, calc_lo;

  // Full-result arithmetic; the result is captured once at start and held until commit.
  always_comb begin
    a_sx    = {{32{A[31]}}, A};
    b_sx    = {{32{B[31]}}, B};
    a_zx    = {32'd0, A};
    b_zx    = {32'd0, B};
    // Low 64 bits of the sign-extended product equal the signed 64-bit product.
    prod_s  = a_sx * b_sx;
    prod_u  = a_zx * b_zx;
    // Signed divide via magnitudes: quotient truncates toward zero, remainder follows
    // the dividend. 0x80000000 / -1 falls out as 0x80000000 rem 0 with no special case.
    a_mag   = A[31] ? (~A + 32'd1) : A;
    b_mag   = B[31] ? (~B + 32'd1) : B;
    den_s   = (b_mag == 32'd0) ? 32'd1 : b_mag;
    q_s_mag = a_mag / den_s;
    r_s_mag = a_mag % den_s;
    q_s     = (A[31] ^ B[31]) ? (~q_s_mag + 32'd1) : q_s_mag;
    r_s     = A[31] ? (~r_s_mag + 32'd1) : r_s_mag;
    den_u   = (B == 32'd0) ? 32'd1 : B;
    q_u     = A / den_u;
    r_u     = A % den_u;
    calc_hi = 32'd0;
    calc_lo = 32'd0;
    case (op)
      2'b00: begin calc_hi = prod_s[63:32]; calc_lo = prod_s[31:0]; end
      2'b01: begin calc_hi = prod_u[63:32]; calc_lo = prod_u[31:0]; end
      2'b10: begin
        calc_hi = (B == 32'd0) ? A : r_s;
        calc_lo = (B == 32'd0) ? 32'hFFFF_FFFF : q_s;
      end
      default: begin
        calc_hi = (B == 32'd0) ? A : r_u;
        calc_lo = (B == 32'd0) ? 32'hFFFF_FFFF : q_u;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  // FSM next state: flush always returns to idle, including in the commit cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (start && !flush) state_d = op[1] ? S_DIV : S_MUL;
      S_MUL, S_DIV: if (flush || cnt_q == CNT_ONE) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM outputs and control strobes.
  always_comb begin
    busy   = (state_q != S_IDLE);
    stall  = start | busy;
    accept = (state_q == S_IDLE) && start && !flush;
    commit = busy && (cnt_q == CNT_ONE) && !flush;
    mt_wr  = (state_q == S_IDLE) && !start && !flush && MUL_DIV_Wr;
    HI_LO  = MUL_DIV_Sel ? hi_q : lo_q;
    HI     = hi_q;
    LO     = lo_q;
  end

  // Datapath next state: counter, shadow result, and architectural HI/LO.
  always_comb begin
    cnt_d    = cnt_q;
    res_hi_d = res_hi_q;
    res_lo_d = res_lo_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    if (accept) begin
      cnt_d    = op[1] ? DIV_CNT : MUL_CNT;
      res_hi_d = calc_hi;
      res_lo_d = calc_lo;
    end else if (busy) begin
      cnt_d = flush ? '0 : (cnt_q - CNT_ONE);
    end
    if (commit) begin
      hi_d = res_hi_q;
      lo_d = res_lo_q;
    end else if (mt_wr) begin
      if (MUL_DIV_Sel) hi_d = A;
      else             lo_d = A;
    end
  end

  // Datapath registers; reset clears everything so no partial commit survives.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q    <= '0;
      res_hi_q <= 32'd0;
      res_lo_q <= 32'd0;
      hi_q     <= 32'd0;
      lo_q     <= 32'd0;
    end else begin
      cnt_q    <= cnt_d;
      res_hi_q <= res_hi_d;
      res_lo_q <= res_lo_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
    end
  end

endmodule
